// File: rtl/sort_engine.sv
// sort_engine: iterative odd-even transposition sorter with valid/ready handshakes on both sides.
// Optional build macro EARLY_EXIT_EN: finish after two consecutive swap-free phases.
module sort_engine #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*W-1:0]         in_data,
    input  logic                   in_desc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*W-1:0]         out_data,
    output logic [$clog2(N+1)-1:0] out_phases
);
    localparam int PW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t         state, state_next;
    logic [N*W-1:0] data_q, data_exch;
    logic [PW-1:0]  phase_q;
    logic           desc_q;
    logic           last_phase, sort_done;
`ifdef EARLY_EXIT_EN
    logic           any_swap, swapped_q;
`endif

    assign last_phase = (phase_q == PW'(N - 1));

    // One compare-exchange phase: pairs start at even or odd index by phase parity.
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        data_exch = data_q;
`ifdef EARLY_EXIT_EN
        any_swap = 1'b0;
`endif
        for (int i = 0; i < N - 1; i++) begin
            if (((i % 2) == int'(phase_q[0])) &&
                (desc_q ? (data_q[i*W +: W] < data_q[(i+1)*W +: W])
                        : (data_q[i*W +: W] > data_q[(i+1)*W +: W]))) begin
                data_exch[i*W +: W]     = data_q[(i+1)*W +: W];
                data_exch[(i+1)*W +: W] = data_q[i*W +: W];
`ifdef EARLY_EXIT_EN
                any_swap = 1'b1;
`endif
            end
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        sort_done  = last_phase;
`ifdef EARLY_EXIT_EN
        // Two clean phases in a row (one even, one odd) prove the vector is sorted.
        if (phase_q != '0 && !any_swap && !swapped_q) sort_done = 1'b1;
`endif
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = SORT;
            end
            SORT: begin
                if (sort_done) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: the working vector is reset because it drives out_data, which must read zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q    <= '0;
            phase_q   <= '0;
            desc_q    <= 1'b0;
`ifdef EARLY_EXIT_EN
            swapped_q <= 1'b0;
`endif
        end else if (state == IDLE && in_valid) begin
            data_q    <= in_data;
            desc_q    <= in_desc;
            phase_q   <= '0;
`ifdef EARLY_EXIT_EN
            swapped_q <= 1'b1;
`endif
        end else if (state == SORT) begin
            data_q    <= data_exch;
            phase_q   <= phase_q + PW'(1);
`ifdef EARLY_EXIT_EN
            swapped_q <= any_swap;
`endif
        end
    end

    // The phase counter equals phases executed once SORT ends and holds through DONE.
    assign out_data   = data_q;
    assign out_phases = phase_q;

endmodule

// File: tb/tb_sort_engine.sv
// Self-checking bench for sort_engine: directed N=4/W=4 scenarios plus random N=8/W=8 traffic.
`timescale 1ns/1ps
module tb_sort_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic        a_in_valid, a_in_ready, a_in_desc, a_out_valid, a_out_ready;
    logic [15:0] a_in_data, a_out_data;
    logic [2:0]  a_out_phases;

    logic        b_in_valid, b_in_ready, b_in_desc, b_out_valid, b_out_ready;
    logic [63:0] b_in_data, b_out_data;
    logic [3:0]  b_out_phases;

    sort_engine #(.N(4), .W(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_desc(a_in_desc),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_phases(a_out_phases)
    );

    sort_engine #(.N(8), .W(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_desc(b_in_desc),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_phases(b_out_phases)
    );

    typedef int q_t[$];

    function automatic q_t unpack_vec(logic [63:0] v, int n, int w);
        q_t q;
        for (int i = 0; i < n; i++) q.push_back(int'((v >> (i * w)) & ((64'd1 << w) - 64'd1)));
        return q;
    endfunction

    function automatic logic [63:0] pack_vec(q_t q, int w);
        logic [63:0] v = '0;
        for (int i = 0; i < q.size(); i++) v = v | (64'(q[i]) << (i * w));
        return v;
    endfunction

    function automatic q_t ref_sort(q_t q, bit desc);
        q_t r = q;
        if (desc) r.rsort();
        else      r.sort();
        return r;
    endfunction

    // Phases the engine needs: N without early exit, else stop after two clean phases in a row.
    function automatic int ref_phases(q_t q, bit desc);
        q_t a = q;
        int n = q.size();
        bit clean_prev = 1'b0;
        bit sw;
        int t;
        if (!EE) return n;
        for (int p = 0; p < n; p++) begin
            sw = 1'b0;
            for (int i = p % 2; i + 1 < n; i += 2) begin
                if (desc ? (a[i] < a[i+1]) : (a[i] > a[i+1])) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t; sw = 1'b1;
                end
            end
            if (p >= 1 && !sw && clean_prev) return p + 1;
            clean_prev = !sw;
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run4(input logic [15:0] vec, input logic desc,
                        output logic [15:0] res, output int lat, output int ph);
        int guard = 0;
        while (!a_in_ready && guard < 20) begin tick(); guard++; end
        a_in_data = vec; a_in_desc = desc; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 20) begin tick(); lat++; end
        if (!a_out_valid) begin
            checks++; errors++;
            $display("FAIL run4_timeout vec=%h out_valid never rose", vec);
        end
        res = a_out_data;
        ph  = int'(a_out_phases);
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++; if (a_in_ready !== 1'b1)    begin errors++; $display("FAIL rst_in_ready4 got %b want 1", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0)   begin errors++; $display("FAIL rst_out_valid4 got %b want 0", a_out_valid); end
        checks++; if (a_out_data !== 16'h0)   begin errors++; $display("FAIL rst_out_data4 got %h want 0", a_out_data); end
        checks++; if (a_out_phases !== 3'd0)  begin errors++; $display("FAIL rst_out_phases4 got %0d want 0", a_out_phases); end
        checks++; if (b_in_ready !== 1'b1)    begin errors++; $display("FAIL rst_in_ready8 got %b want 1", b_in_ready); end
        checks++; if (b_out_valid !== 1'b0)   begin errors++; $display("FAIL rst_out_valid8 got %b want 0", b_out_valid); end
        checks++; if (b_out_data !== 64'h0)   begin errors++; $display("FAIL rst_out_data8 got %h want 0", b_out_data); end
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0)
            begin errors++; $display("FAIL post_rst_idle got ready=%b valid=%b want 1/0", a_in_ready, a_out_valid); end
    endtask

    task automatic test_sort_basic();
        logic [15:0] vin [3] = '{16'h0213, 16'h0213, 16'h2022};
        logic        din [3] = '{1'b0, 1'b1, 1'b0};
        logic [15:0] vexp[3] = '{16'h3210, 16'h0123, 16'h2220};
        logic [15:0] res;
        int lat, ph, ph_exp;
        for (int k = 0; k < 3; k++) begin
            ph_exp = ref_phases(unpack_vec(64'(vin[k]), 4, 4), din[k]);
            run4(vin[k], din[k], res, lat, ph);
            checks++; if (res !== vexp[k]) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", k, res, vexp[k]); end
            checks++; if (ph !== ph_exp)   begin errors++; $display("FAIL basic_phases[%0d] got %0d want %0d", k, ph, ph_exp); end
            checks++; if (lat !== ph_exp)  begin errors++; $display("FAIL basic_latency[%0d] got %0d want %0d", k, lat, ph_exp); end
        end
    endtask

    task automatic test_early_exit();
        logic [15:0] res;
        int lat, ph;
        int ph_exp = EE ? 2 : 4;
        run4(16'h3210, 1'b0, res, lat, ph);
        checks++; if (res !== 16'h3210) begin errors++; $display("FAIL sorted_data got %h want 3210", res); end
        checks++; if (ph !== ph_exp)    begin errors++; $display("FAIL sorted_phases got %0d want %0d", ph, ph_exp); end
        checks++; if (lat !== ph_exp)   begin errors++; $display("FAIL sorted_latency got %0d want %0d", lat, ph_exp); end
    endtask

    task automatic test_backpressure();
        int guard = 0;
        a_out_ready = 1'b0;
        a_in_data = 16'h0213; a_in_desc = 1'b0; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        while (!a_out_valid && guard < 20) begin tick(); guard++; end
        checks++; if (a_out_data !== 16'h3210) begin errors++; $display("FAIL bp_data got %h want 3210", a_out_data); end
        for (int k = 0; k < 5; k++) begin
            a_in_valid = 1'b1; a_in_data = 16'hABCD; a_in_desc = 1'b1;
            checks++; if (a_out_valid !== 1'b1)     begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", k, a_out_valid); end
            checks++; if (a_out_data !== 16'h3210)  begin errors++; $display("FAIL bp_hold[%0d] got %h want 3210", k, a_out_data); end
            checks++; if (a_in_ready !== 1'b0)      begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", k, a_in_ready); end
            tick();
        end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b0;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1)  begin errors++; $display("FAIL bp_release_ready got %b want 1", a_in_ready); end
        tick(); tick();
        checks++; if (a_in_ready !== 1'b1)  begin errors++; $display("FAIL bp_no_capture got in_ready=%b want 1", a_in_ready); end
        checks++; if (a_out_data !== 16'h3210) begin errors++; $display("FAIL bp_no_capture_data got %h want 3210", a_out_data); end
    endtask

    task automatic test_reset_mid_sort();
        logic [15:0] res;
        int lat, ph, ph_exp;
        a_in_data = 16'h0213; a_in_desc = 1'b0; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        checks++; if (a_out_valid !== 1'b0)  begin errors++; $display("FAIL midrst_valid got %b want 0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1)   begin errors++; $display("FAIL midrst_ready got %b want 1", a_in_ready); end
        checks++; if (a_out_data !== 16'h0)  begin errors++; $display("FAIL midrst_data got %h want 0", a_out_data); end
        checks++; if (a_out_phases !== 3'd0) begin errors++; $display("FAIL midrst_phases got %0d want 0", a_out_phases); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (a_out_valid !== 1'b0)  begin errors++; $display("FAIL midrst_no_emit got %b want 0", a_out_valid); end
        ph_exp = ref_phases(unpack_vec(64'h0F0F, 4, 4), 1'b0);
        run4(16'h0F0F, 1'b0, res, lat, ph);
        checks++; if (res !== 16'hFF00) begin errors++; $display("FAIL after_rst_data got %h want ff00", res); end
        checks++; if (ph !== ph_exp)    begin errors++; $display("FAIL after_rst_phases got %0d want %0d", ph, ph_exp); end
    endtask

    task automatic test_random8();
        logic [63:0] vec, got, want;
        logic        desc;
        int cyc, guard, ph_exp;
        int hist[256];
        bit hs, perm_ok;
        q_t q_in, q_out;
        for (int it = 0; it < 200; it++) begin
            vec  = {$urandom(), $urandom()};
            if (it % 10 == 0) vec = {8{8'hFF}} & ~(64'(it % 3) << 8);
            desc = 1'(($urandom() % 2));
            q_in = unpack_vec(vec, 8, 8);
            want = pack_vec(ref_sort(q_in, desc), 8);
            ph_exp = ref_phases(q_in, desc);
            guard = 0;
            while (!b_in_ready && guard < 20) begin tick(); guard++; end
            b_in_data = vec; b_in_desc = desc; b_in_valid = 1'b1;
            b_out_ready = 1'(($urandom() % 2));
            tick();
            b_in_valid = 1'b0;
            cyc = 0;
            while (!b_out_valid && cyc < 30) begin
                b_out_ready = 1'(($urandom() % 2));
                tick();
                cyc++;
            end
            if (!b_out_valid) begin
                checks++; errors++;
                $display("FAIL rand_timeout[%0d] out_valid never rose", it);
            end
            got = b_out_data;
            checks++; if (got !== want)   begin errors++; $display("FAIL rand_data[%0d] in=%h desc=%b got %h want %h", it, vec, desc, got, want); end
            checks++; if (int'(b_out_phases) !== ph_exp) begin errors++; $display("FAIL rand_phases[%0d] got %0d want %0d", it, b_out_phases, ph_exp); end
            checks++; if (cyc !== ph_exp) begin errors++; $display("FAIL rand_latency[%0d] got %0d want %0d", it, cyc, ph_exp); end
            for (int v = 0; v < 256; v++) hist[v] = 0;
            q_out = unpack_vec(got, 8, 8);
            foreach (q_in[i])  hist[q_in[i]]++;
            foreach (q_out[i]) hist[q_out[i]]--;
            perm_ok = 1'b1;
            for (int v = 0; v < 256; v++) if (hist[v] != 0) perm_ok = 1'b0;
            checks++; if (!perm_ok) begin errors++; $display("FAIL rand_perm[%0d] got %h from input %h", it, got, vec); end
            guard = 0;
            do begin
                hs = 1'(($urandom() % 2));
                if (guard >= 40) hs = 1'b1;
                b_out_ready = hs;
                tick();
                guard++;
            end while (!hs);
            b_out_ready = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_desc = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_desc = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        test_reset();
        test_sort_basic();
        test_early_exit();
        test_backpressure();
        test_reset_mid_sort();
        test_random8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
